// File: rtl/encoder16to4_pipe_pkg.sv
// rtl/encoder16to4_pipe_pkg.sv - shared constants and encode helpers for the cache lookup path
package encoder16to4_pipe_pkg;

    localparam int IDX_W = 4;
    localparam int N     = 2 ** IDX_W;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             hit;
        logic             multi;
    } enc_result_t;

    // Scan from the top so the last write is the lowest set bit.
    function automatic logic [IDX_W-1:0] lowest_set_index(input logic [N-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Clearing the lowest set bit leaves something only when two or more were set.
    function automatic logic is_multi_hot(input logic [N-1:0] vec);
        return (vec & (vec - N'(1))) != '0;
    endfunction

endpackage

// File: rtl/encoder16to4_pipe_priority_encoder16.sv
// rtl/encoder16to4_pipe_priority_encoder16.sv - combinational 16-to-4 lowest-index priority encoder
module priority_encoder16
    import encoder16to4_pipe_pkg::*;
(
    input  logic [N-1:0]     in,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    always_comb begin
        idx   = lowest_set_index(in);
        any   = |in;
        multi = is_multi_hot(in);
    end

endmodule

// File: rtl/encoder16to4_pipe.sv
// rtl/encoder16to4_pipe.sv - registered one-hot to index encoder with valid/ready stage and multi-hot counter
module encoder16to4_pipe #(
    parameter int IDX_W = 4,
    parameter int N     = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out,
    output logic             out_hit,
    output logic             out_multi,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
);
    import encoder16to4_pipe_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    out_state_t       state;
    out_state_t       state_nxt;
    logic             accept;
    logic             transfer;
    logic             load;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             enc_multi;
    enc_result_t      result_nxt;
    logic             err_inc;

    priority_encoder16 u_prienc (
        .in    (in),
        .idx   (enc_idx),
        .any   (enc_any),
        .multi (enc_multi)
    );

    // The held result can be replaced in the same cycle it is consumed.
    assign in_ready  = (state == EMPTY) | out_ready;
    assign accept    = in_valid & in_ready;
    assign transfer  = out_valid & out_ready;
    assign out_valid = (state == FULL);
    assign err_inc   = accept & enable & enc_multi;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = FULL;
                    load      = 1'b1;
                end
            end
            FULL: begin
                if (transfer && accept) begin
                    load = 1'b1;
                end else if (transfer) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // A disabled lookup still produces a transfer, just a guaranteed miss.
    always_comb begin
        result_nxt = '0;
        if (enable) begin
            result_nxt.idx   = enc_idx;
            result_nxt.hit   = enc_any;
            result_nxt.multi = enc_multi;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= '0;
            out_hit   <= 1'b0;
            out_multi <= 1'b0;
        end else if (load) begin
            out       <= result_nxt.idx;
            out_hit   <= result_nxt.hit;
            out_multi <= result_nxt.multi;
        end
    end

    // Clear wins first, then a coincident increment counts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= err_inc ? CNT_W'(1) : '0;
        end else if (err_inc && (err_count != CNT_MAX)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule
